sequential_buffer: RTL and testbench

Parametrised circular buffer that succeeds the fixed 16-entry write-then-read store. It accepts one word per rising edge of `request_write` and returns one word per rising edge of `request_read`, in first-in-first-out order. Pointers wrap, so writing and reading can interleave indefinitely. The block sits between a slow, request-driven producer/consumer pair and reports occupancy, full/empty and sticky error flags so the surrounding control can pace itself.

---
 rtl/sequential_buffer.sv | 149 ++++++++++++++
 tb/tb_sequential_buffer.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sequential_buffer.sv
// sequential_buffer
//
// Parametrised circular FIFO driven by level requests. A word is accepted on
// each rising edge of request_write and returned on each rising edge of
// request_read, in first-in-first-out order. Pointers wrap so writes and
// reads may interleave indefinitely. Occupancy, full/empty and sticky error
// flags let the surrounding control pace itself.
//
// Ports:
//   clk            sole clock, rising edge
//   reset          asynchronous, active-high; clears all state
//   request_write  level request; write taken on its rising edge
//   request_read   level request; read taken on its rising edge
//   clear          synchronous flush, active-high, beats all requests
//   data_in        word captured on an accepted write
//   data_out       last word read (registered)
//   correct_read   buffer is non-empty
//   full           count == DEPTH
//   count          number of stored words, 0..DEPTH
//   overflow       sticky: write edge while full
//   underflow      sticky: read edge while empty

module sequential_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  request_write,
  input  logic                  request_read,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  correct_read,
  output logic                  full,
  output logic [AW:0]           count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_q, wr_d;
  logic                  rd_q, rd_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic wr_edge, rd_edge;
  logic is_full, is_empty;
  logic do_write, do_read;

  // Next-state logic. Full/empty are judged on the pre-edge count, so a
  // simultaneous read lets a write into a full buffer, while on an empty
  // buffer the write lands but the read cannot see it in the same cycle.
  // Clear drops any edges of this cycle, but the request levels are still
  // recorded so those edges are consumed rather than deferred.
  always_comb begin
    wr_edge  = request_write && !wr_q;
    rd_edge  = request_read && !rd_q;
    is_full  = (count_q == FULL_COUNT);
    is_empty = (count_q == '0);
    do_write = !clear && wr_edge && (!is_full || rd_edge);
    do_read  = !clear && rd_edge && !is_empty;

    wr_d        = request_write;
    rd_d        = request_read;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (do_read) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        data_out_d = mem_q[rd_ptr_q];
      end
      case ({do_write, do_read})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (wr_edge && is_full && !rd_edge) begin
        overflow_d = 1'b1;
      end
      if (rd_edge && is_empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  // Control state. The request history resets to 1 so that a request held
  // high through reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q        <= 1'b1;
      rd_q        <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array. It is never reset or flushed; only the pointers and
  // count define which entries are live. Writes are blocked while reset is
  // high so nothing commits on an edge that reset overlaps.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  assign data_out     = data_out_q;
  assign count        = count_q;
  assign full         = is_full;
  assign correct_read = !is_empty;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

endmodule

// File: tb/tb_sequential_buffer.sv
// tb_sequential_buffer
//
// Self-checking bench for sequential_buffer. Three instances are built:
// index 0 is DEPTH=16/DATA_WIDTH=8, index 1 is DEPTH=2/DATA_WIDTH=1 and
// index 2 is DEPTH=64/DATA_WIDTH=32. Each has its own request and clear
// lines; clock, reset and the data bus are shared. Expected behaviour comes
// from a queue-based reference model per instance.

module tb_sequential_buffer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_req [3];
  logic        rd_req [3];
  logic        clr    [3];
  logic [31:0] din = '0;

  logic [7:0]  d0_out;
  logic [0:0]  d1_out;
  logic [31:0] d2_out;
  logic [4:0]  d0_cnt;
  logic [1:0]  d1_cnt;
  logic [6:0]  d2_cnt;

  logic [31:0] dout_a [3];
  logic [7:0]  cnt_a  [3];
  logic        full_a [3];
  logic        cr_a   [3];
  logic        ovf_a  [3];
  logic        unf_a  [3];

  int checks = 0;
  int errors = 0;

  int          depth_m [3] = '{16, 2, 64};
  logic [31:0] mask_m  [3] = '{32'h0000_00FF, 32'h0000_0001, 32'hFFFF_FFFF};

  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];
  logic [31:0] m_dout [3];
  logic        m_ovf  [3];
  logic        m_unf  [3];

  always #5 clk = ~clk;

  sequential_buffer #(.DATA_WIDTH(8), .DEPTH(16)) dut0 (
    .clk(clk), .reset(reset),
    .request_write(wr_req[0]), .request_read(rd_req[0]), .clear(clr[0]),
    .data_in(din[7:0]), .data_out(d0_out), .correct_read(cr_a[0]),
    .full(full_a[0]), .count(d0_cnt), .overflow(ovf_a[0]), .underflow(unf_a[0])
  );

  sequential_buffer #(.DATA_WIDTH(1), .DEPTH(2)) dut1 (
    .clk(clk), .reset(reset),
    .request_write(wr_req[1]), .request_read(rd_req[1]), .clear(clr[1]),
    .data_in(din[0:0]), .data_out(d1_out), .correct_read(cr_a[1]),
    .full(full_a[1]), .count(d1_cnt), .overflow(ovf_a[1]), .underflow(unf_a[1])
  );

  sequential_buffer #(.DATA_WIDTH(32), .DEPTH(64)) dut2 (
    .clk(clk), .reset(reset),
    .request_write(wr_req[2]), .request_read(rd_req[2]), .clear(clr[2]),
    .data_in(din), .data_out(d2_out), .correct_read(cr_a[2]),
    .full(full_a[2]), .count(d2_cnt), .overflow(ovf_a[2]), .underflow(unf_a[2])
  );

  assign dout_a[0] = {24'b0, d0_out};
  assign dout_a[1] = {31'b0, d1_out};
  assign dout_a[2] = d2_out;
  assign cnt_a[0]  = {3'b0, d0_cnt};
  assign cnt_a[1]  = {6'b0, d1_cnt};
  assign cnt_a[2]  = {1'b0, d2_cnt};

  // Reference model: an unbounded queue per instance plus the last word read
  // and the two sticky flags.
  function automatic int m_size(input int idx);
    case (idx)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void m_push(input int idx, input logic [31:0] v);
    case (idx)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endfunction

  function automatic logic [31:0] m_pop(input int idx);
    case (idx)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  function automatic void m_flush(input int idx);
    case (idx)
      0:       q0.delete();
      1:       q1.delete();
      default: q2.delete();
    endcase
    m_ovf[idx] = 1'b0;
    m_unf[idx] = 1'b0;
  endfunction

  function automatic void m_reset_all();
    for (int i = 0; i < 3; i++) begin
      m_flush(i);
      m_dout[i] = '0;
    end
  endfunction

  // Packed status {count, full, correct_read, overflow, underflow, data_out}.
  function automatic logic [43:0] exp_status(input int idx);
    int sz;
    sz = m_size(idx);
    return {8'(sz), (sz == depth_m[idx]), (sz != 0), m_ovf[idx], m_unf[idx], m_dout[idx]};
  endfunction

  function automatic logic [43:0] obs_status(input int idx);
    return {cnt_a[idx], full_a[idx], cr_a[idx], ovf_a[idx], unf_a[idx], dout_a[idx]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One request pulse (high for a cycle, low for a cycle) on the chosen
  // lines, followed by the matching model update. Full/empty in the model is
  // decided by the occupancy before the edge.
  task automatic pulse(input int idx, input bit w, input bit r, input logic [31:0] data);
    int sz;
    logic [31:0] d;
    d  = data & mask_m[idx];
    sz = m_size(idx);
    din = d;
    if (w) wr_req[idx] = 1'b1;
    if (r) rd_req[idx] = 1'b1;
    step();
    if (w) wr_req[idx] = 1'b0;
    if (r) rd_req[idx] = 1'b0;
    step();
    if (w && r) begin
      if (sz == 0) begin
        m_push(idx, d);
        m_unf[idx] = 1'b1;
      end else begin
        m_dout[idx] = m_pop(idx);
        m_push(idx, d);
      end
    end else if (w) begin
      if (sz == depth_m[idx]) m_ovf[idx] = 1'b1;
      else m_push(idx, d);
    end else if (r) begin
      if (sz == 0) m_unf[idx] = 1'b1;
      else m_dout[idx] = m_pop(idx);
    end
  endtask

  task automatic do_clear(input int idx);
    clr[idx] = 1'b1;
    step();
    clr[idx] = 1'b0;
    step();
    m_flush(idx);
  endtask

  task automatic apply_reset();
    #2;
    reset = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    m_reset_all();
    step();
  endtask

  task automatic test_reset();
    logic [43:0] obs, exp;
    $display("[TB] test_reset");
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      obs = obs_status(i);
      exp = 44'h0;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL reset dut%0d: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_fill_drain(input int idx, input bit ramp);
    logic [43:0] obs, exp;
    $display("[TB] test_fill_drain dut%0d", idx);
    for (int i = 0; i < depth_m[idx]; i++) begin
      pulse(idx, 1'b1, 1'b0, ramp ? 32'(32'h10 + i) : $urandom);
      obs = obs_status(idx);
      exp = exp_status(idx);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL fill dut%0d #%0d: got %h expected %h", idx, i, obs, exp);
      end
    end
    checks++;
    if (cnt_a[idx] !== 8'(depth_m[idx]) || full_a[idx] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_count dut%0d: got count %0d full %b expected %0d 1",
               idx, cnt_a[idx], full_a[idx], depth_m[idx]);
    end
    for (int i = 0; i < depth_m[idx]; i++) begin
      pulse(idx, 1'b0, 1'b1, 32'h0);
      obs = obs_status(idx);
      exp = exp_status(idx);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL drain dut%0d #%0d: got %h expected %h", idx, i, obs, exp);
      end
    end
  endtask

  task automatic test_overflow();
    logic [43:0] obs, exp;
    $display("[TB] test_overflow");
    for (int i = 0; i < 16; i++) pulse(0, 1'b1, 1'b0, 32'(32'h10 + i));
    pulse(0, 1'b1, 1'b0, 32'hAA);
    obs = obs_status(0);
    exp = exp_status(0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL overflow_set: got %h expected %h", obs, exp);
    end
    for (int i = 0; i < 16; i++) begin
      pulse(0, 1'b0, 1'b1, 32'h0);
      checks++;
      if (dout_a[0] !== 32'(32'h10 + i) || ovf_a[0] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL overflow_drain #%0d: got %h ovf %b expected %h ovf 1",
                 i, dout_a[0], ovf_a[0], 32'h10 + i);
      end
    end
  endtask

  task automatic test_underflow();
    logic [43:0] obs, exp;
    $display("[TB] test_underflow");
    pulse(0, 1'b0, 1'b1, 32'h0);
    obs = obs_status(0);
    exp = exp_status(0);
    checks++;
    if (obs !== exp || dout_a[0] !== 32'h1F) begin
      errors++;
      $display("[TB] FAIL underflow_set: got %h expected %h", obs, exp);
    end
    clr[0] = 1'b1;
    wr_req[0] = 1'b1;
    din = 32'h55;
    step();
    clr[0] = 1'b0;
    step();
    wr_req[0] = 1'b0;
    step();
    m_flush(0);
    obs = obs_status(0);
    exp = exp_status(0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL clear_flags: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_wrap(input int idx);
    logic [43:0] obs, exp;
    int nw;
    $display("[TB] test_wrap dut%0d", idx);
    nw = depth_m[idx] - depth_m[idx] / 4;
    for (int i = 0; i < nw; i++) pulse(idx, 1'b1, 1'b0, $urandom);
    for (int i = 0; i < nw - 2; i++) pulse(idx, 1'b0, 1'b1, 32'h0);
    for (int i = 0; i < 40; i++) begin
      pulse(idx, 1'b1, 1'b1, $urandom);
      obs = obs_status(idx);
      exp = exp_status(idx);
      checks++;
      if (obs !== exp || cnt_a[idx] !== 8'd2) begin
        errors++;
        $display("[TB] FAIL wrap_simul dut%0d #%0d: got %h expected %h", idx, i, obs, exp);
      end
    end
    while (m_size(idx) < depth_m[idx]) pulse(idx, 1'b1, 1'b0, $urandom);
    pulse(idx, 1'b1, 1'b1, $urandom);
    obs = obs_status(idx);
    exp = exp_status(idx);
    checks++;
    if (obs !== exp || cnt_a[idx] !== 8'(depth_m[idx])) begin
      errors++;
      $display("[TB] FAIL simul_full dut%0d: got %h expected %h", idx, obs, exp);
    end
    while (m_size(idx) > 0) pulse(idx, 1'b0, 1'b1, 32'h0);
    pulse(idx, 1'b1, 1'b1, $urandom);
    obs = obs_status(idx);
    exp = exp_status(idx);
    checks++;
    if (obs !== exp || cnt_a[idx] !== 8'd1 || unf_a[idx] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL simul_empty dut%0d: got %h expected %h", idx, obs, exp);
    end
    do_clear(idx);
  endtask

  task automatic test_held_and_reset();
    logic [43:0] obs, exp;
    logic [31:0] first;
    $display("[TB] test_held_and_reset");
    din = $urandom & mask_m[0];
    wr_req[0] = 1'b1;
    repeat (5) step();
    wr_req[0] = 1'b0;
    step();
    m_push(0, din);
    obs = obs_status(0);
    exp = exp_status(0);
    checks++;
    if (obs !== exp || cnt_a[0] !== 8'd1) begin
      errors++;
      $display("[TB] FAIL held_write: got %h expected %h", obs, exp);
    end
    for (int i = 0; i < 6; i++) pulse(0, 1'b1, 1'b0, $urandom);
    checks++;
    if (cnt_a[0] !== 8'd7) begin
      errors++;
      $display("[TB] FAIL pre_reset_count: got %0d expected 7", cnt_a[0]);
    end
    #2;
    reset = 1'b1;
    rd_req[0] = 1'b1;
    #1;
    m_reset_all();
    obs = obs_status(0);
    exp = exp_status(0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h expected %h", obs, exp);
    end
    @(posedge clk);
    #3;
    reset = 1'b0;
    repeat (3) step();
    first = $urandom & mask_m[0];
    pulse(0, 1'b1, 1'b0, first);
    pulse(0, 1'b1, 1'b0, $urandom);
    obs = obs_status(0);
    exp = exp_status(0);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL held_read_ignored: got %h expected %h", obs, exp);
    end
    rd_req[0] = 1'b0;
    step();
    pulse(0, 1'b0, 1'b1, 32'h0);
    obs = obs_status(0);
    exp = exp_status(0);
    checks++;
    if (obs !== exp || dout_a[0] !== first) begin
      errors++;
      $display("[TB] FAIL read_after_toggle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_random(input int idx, input int n);
    logic [43:0] obs, exp;
    int op;
    $display("[TB] test_random dut%0d", idx);
    for (int i = 0; i < n; i++) begin
      op = $urandom_range(0, 9);
      if (op < 4) pulse(idx, 1'b1, 1'b0, $urandom);
      else if (op < 7) pulse(idx, 1'b0, 1'b1, 32'h0);
      else if (op < 9) pulse(idx, 1'b1, 1'b1, $urandom);
      else do_clear(idx);
      obs = obs_status(idx);
      exp = exp_status(idx);
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("[TB] FAIL random dut%0d #%0d: got %h expected %h", idx, i, obs, exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      wr_req[i] = 1'b0;
      rd_req[i] = 1'b0;
      clr[i]    = 1'b0;
    end
    m_reset_all();
    test_reset();
    test_fill_drain(0, 1'b1);
    test_overflow();
    test_underflow();
    test_wrap(0);
    test_held_and_reset();
    test_random(0, 200);
    for (int i = 1; i < 3; i++) begin
      test_fill_drain(i, 1'b0);
      test_wrap(i);
      test_random(i, 100);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
